ccff_prog_ctrl: RTL

Sequencer that programs the fabric configuration chain, the serial string of `dffr` configuration flops. It accepts bitstream words over a valid/ready stream, serializes them MSB-first onto the chain head with a per-bit shift enable, and counts exactly the requested number of bits. While programming is in progress it holds the GPIO pads isolated, forcing `DIR` to input. It sits between the bitstream loader and the fabric top-level `ccff_head` input.

---
 rtl/ccff_prog_pkg.sv | 15 +
 rtl/ccff_serializer.sv | 36 +++
 rtl/ccff_prog_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ccff_prog_pkg.sv
// Shared types and sizing helpers for the configuration-chain programming sequencer.
package ccff_prog_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StShift,
    StFinish
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/ccff_serializer.sv
// Word shift register feeding the chain head, MSB first, with a per-word bit down-counter.
module ccff_serializer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned BIT_W  = $clog2(WORD_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_word,
  input  logic [BIT_W-1:0]  i_bits,
  output logic              o_msb,
  output logic [BIT_W-1:0]  o_bits
);

  logic [WORD_W-1:0] r_sreg;
  logic [BIT_W-1:0]  r_bits;

  // A load wins over a shift so a new word can follow the last bit with no bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg <= '0;
      r_bits <= '0;
    end else if (i_load) begin
      r_sreg <= i_word;
      r_bits <= i_bits;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
      r_bits <= r_bits - BIT_W'(1);
    end
  end

  assign o_msb  = r_sreg[WORD_W-1];
  assign o_bits = r_bits;

endmodule

// File: rtl/ccff_prog_ctrl.sv
// Programs the fabric configuration chain from a valid/ready word stream, holding GPIO isolated
// while a session is active.
module ccff_prog_ctrl
  import ccff_prog_pkg::*;
#(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned MAX_LEN = 4096,
  localparam int unsigned CNT_W  = cnt_w(MAX_LEN)
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [CNT_W-1:0]  LEN,
  input  logic              ABORT,
  input  logic              DATA_VALID,
  input  logic [WORD_W-1:0] DATA_WORD,
  output logic              DATA_READY,
  output logic              CCFF_HEAD,
  output logic              CCFF_EN,
  output logic              IO_ISOL,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORTED
);

  localparam int unsigned BIT_W = $clog2(WORD_W + 1);

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_rem, w_rem_d;
  logic               r_en, r_aborted, r_guard;
  logic               w_load, w_shift, w_hs, w_word_end, w_last, w_msb;
  logic [CNT_W-1:0]   w_len_sat;
  logic [BIT_W-1:0]   w_bits, w_bits_load;

  assign w_len_sat   = (LEN > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : LEN;
  assign w_word_end  = (w_bits == BIT_W'(1));
  assign w_last      = (r_rem == CNT_W'(1));
  assign w_hs        = DATA_VALID && DATA_READY;
  // Size of the word being loaded uses the post-decrement count, so reloads mid-shift line up.
  assign w_bits_load = (w_rem_d >= CNT_W'(WORD_W)) ? BIT_W'(WORD_W) : BIT_W'(w_rem_d);

  assign DATA_READY = (r_state == StFetch) ||
                      ((r_state == StShift) && w_word_end && !w_last);

  always_comb begin
    w_state_d = r_state;
    w_rem_d   = r_rem;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (START) begin
          if (w_len_sat == '0) begin
            w_state_d = StFinish;
          end else begin
            w_rem_d   = w_len_sat;
            w_state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (w_hs) begin
          w_load    = 1'b1;
          w_state_d = StShift;
        end
      end
      StShift: begin
        w_shift = 1'b1;
        w_rem_d = r_rem - CNT_W'(1);
        if (w_word_end) begin
          if (w_last) begin
            w_state_d = StFinish;
          end else if (w_hs) begin
            w_load = 1'b1;
          end else begin
            w_state_d = StFetch;
          end
        end
      end
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    // A word accepted in the abort cycle is consumed but never loaded.
    if (ABORT && (r_state != StIdle)) begin
      w_state_d = StIdle;
      w_load    = 1'b0;
      w_shift   = 1'b0;
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= StIdle;
      r_rem     <= '0;
      r_en      <= 1'b0;
      r_aborted <= 1'b0;
      r_guard   <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_rem     <= w_rem_d;
      r_en      <= (w_state_d == StShift);
      r_aborted <= ABORT && (r_state != StIdle);
      r_guard   <= (r_state == StFinish);
    end
  end

  ccff_serializer #(
    .WORD_W (WORD_W),
    .BIT_W  (BIT_W)
  ) u_ser (
    .i_clk   (CK),
    .i_rst_n (RSTN),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_word  (DATA_WORD),
    .i_bits  (w_bits_load),
    .o_msb   (w_msb),
    .o_bits  (w_bits)
  );

  assign CCFF_EN   = r_en;
  assign CCFF_HEAD = w_msb;
  assign BUSY      = (r_state != StIdle);
  assign DONE      = (r_state == StFinish);
  assign ABORTED   = r_aborted;
  // Guard stays high one cycle past FINISH, and throughout reset.
  assign IO_ISOL   = BUSY || r_guard;

endmodule
